// File: rtl/layernorm_int8.sv
// layernorm_int8: sequential int8 layer normalisation of one packed DIM-element vector.
// Phases: sum -> variance -> bit-serial sqrt -> restoring reciprocal -> per-element normalise.
// Optional build macro LAYERNORM_ROUND_EN: round-half-up on the two normalisation shifts
// (undefined: plain floor shifts). Latency is identical in both builds.
module layernorm_int8 #(
    parameter int DIM = 128,
    parameter int EPS = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic [DIM*8-1:0]           in_vec_i,
    output logic [$clog2(DIM)-1:0]     param_addr_o,
    input  logic signed [7:0]          gamma_data_i,
    input  logic signed [7:0]          beta_data_i,
    output logic [DIM*8-1:0]           out_vec_o,
    output logic                       busy_o,
    output logic                       done_o
);
    localparam int LOG = $clog2(DIM);
    localparam int CW  = LOG + 2;
    localparam int YW  = (DIM - 1) * 8;
    localparam logic [CW-1:0] CNT_VEC  = CW'(DIM - 1);
    localparam logic [CW-1:0] CNT_SQRT = CW'(8);
    localparam logic [CW-1:0] CNT_DIV  = CW'(16);
    localparam logic [CW-1:0] CNT_NORM = CW'(DIM);

    typedef enum logic [2:0] {IDLE, SUM, VAR, SQRT, DIV, NORM, DONE} state_t;

    state_t state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [DIM*8-1:0]   xbuf;
    logic [YW-1:0]      ybuf;
    logic signed [15:0] sum;
    logic [23:0]        acc;
    logic [8:0]         root;
    logic [8:0]         rem;
    logic [16:0]        inv;
    logic signed [15:0] n_p0;
    logic               vld_p0;

    logic [LOG-1:0]     idx;
    logic signed [7:0]  xk;
    logic signed [8:0]  mean;
    logic signed [8:0]  d;
    logic signed [17:0] dsq;
    logic [17:0]        rad;
    logic [8:0]         trial;
    logic [17:0]        trial_sq;
    logic [9:0]         rem_sh;
    logic signed [26:0] prod;
    logic signed [15:0] n_nxt;
    logic signed [23:0] pg;
    logic signed [17:0] p;
    logic signed [19:0] ysum;
    logic signed [7:0]  y_p1;

    // (x*inv_std) >> 12 back to Q4, optionally rounded half-up
    function automatic logic signed [15:0] shift_norm(input logic signed [26:0] v);
        logic signed [26:0] t;
`ifdef LAYERNORM_ROUND_EN
        t = v + 27'sd2048;
`else
        t = v;
`endif
        return 16'(t >>> 12);
    endfunction

    // (n*gamma) >> 6 removes the Q1.6 gamma scale, optionally rounded half-up
    function automatic logic signed [17:0] shift_gamma(input logic signed [23:0] v);
        logic signed [23:0] t;
`ifdef LAYERNORM_ROUND_EN
        t = v + 24'sd32;
`else
        t = v;
`endif
        return 18'(t >>> 6);
    endfunction

    // clip to int8 range
    function automatic logic signed [7:0] sat8(input logic signed [19:0] v);
        if (v > 20'sd127)
            return 8'sd127;
        else if (v < -20'sd128)
            return -8'sd128;
        else
            return 8'(v);
    endfunction

    // shared element select, deviation, sqrt trial and divider step
    always_comb begin
        idx      = cnt[LOG-1:0];
        xk       = $signed(xbuf[{idx, 3'b000} +: 8]);
        mean     = 9'(sum >>> LOG);
        d        = $signed({xk[7], xk}) - mean;
        dsq      = d * d;
        rad      = 18'(acc >> LOG) + 18'(EPS);
        trial    = root | (9'd1 << (4'd8 - cnt[3:0]));
        trial_sq = trial * trial;
        rem_sh   = {rem, (cnt == '0)};
        prod     = d * $signed({1'b0, inv});
        n_nxt    = shift_norm(prod);
        pg       = n_p0 * gamma_data_i;
        p        = shift_gamma(pg);
        ysum     = {{2{p[17]}}, p} + {{12{beta_data_i[7]}}, beta_data_i};
        y_p1     = sat8(ysum);
    end

    assign busy_o       = (state != IDLE);
    assign param_addr_o = (state == NORM) ? idx : '0;

    // state register, stage-0 valid and done pulse
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            vld_p0 <= 1'b0;
            done_o <= 1'b0;
        end else begin
            state  <= state_nxt;
            vld_p0 <= (state == NORM) && (cnt != CNT_NORM);
            done_o <= (state == NORM) && (cnt == CNT_NORM);
        end
    end

    // next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_i) state_nxt = SUM;
            SUM:  if (cnt == CNT_VEC) state_nxt = VAR;
            VAR:  if (cnt == CNT_VEC) state_nxt = SQRT;
            SQRT: if (cnt == CNT_SQRT) state_nxt = DIV;
            DIV:  if (cnt == CNT_DIV) state_nxt = NORM;
            NORM: if (cnt == CNT_NORM) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // phase counter and datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt       <= '0;
            xbuf      <= '0;
            ybuf      <= '0;
            sum       <= '0;
            acc       <= '0;
            root      <= '0;
            rem       <= '0;
            inv       <= '0;
            n_p0      <= '0;
            out_vec_o <= '0;
        end else begin
            cnt <= (state_nxt != state) ? '0 : cnt + 1'b1;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        xbuf <= in_vec_i;
                        sum  <= '0;
                        acc  <= '0;
                        root <= '0;
                        rem  <= '0;
                        inv  <= '0;
                    end
                end
                SUM:  sum <= sum + {{8{xk[7]}}, xk};
                VAR:  acc <= acc + {6'b0, dsq};
                SQRT: if (trial_sq <= rad) root <= trial;
                DIV: begin
                    if (rem_sh >= {1'b0, root}) begin
                        rem <= 9'(rem_sh - {1'b0, root});
                        inv <= {inv[15:0], 1'b1};
                    end else begin
                        rem <= rem_sh[8:0];
                        inv <= {inv[15:0], 1'b0};
                    end
                end
                NORM: begin
                    // stage p0: normalised deviation while the ROM read is in flight
                    if (cnt != CNT_NORM) n_p0 <= n_nxt;
                    // stage p1: gamma/beta arrive, result shifts into the output buffer
                    if (vld_p0) begin
                        ybuf <= {y_p1, ybuf[YW-1:8]};
                        if (cnt == CNT_NORM) out_vec_o <= {y_p1, ybuf};
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_layernorm_int8.sv
// Scoreboard bench for layernorm_int8 (DIM=128): directed vectors with hand-computed results.
module tb_layernorm_int8;
    localparam int DIM = 128;
    localparam int W   = DIM * 8;
    localparam int LAT = 411;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [W-1:0]        in_vec;
    logic [6:0]          addr;
    logic signed [7:0]   gamma;
    logic signed [7:0]   beta;
    logic [W-1:0]        out_vec;
    logic                busy;
    logic                done;

    layernorm_int8 #(.DIM(DIM), .EPS(1)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .in_vec_i(in_vec),
        .param_addr_o(addr), .gamma_data_i(gamma), .beta_data_i(beta),
        .out_vec_o(out_vec), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    // parameter ROM model with registered read
    logic signed [7:0] gam [DIM];
    logic signed [7:0] bet [DIM];
    always @(posedge clk) begin
        gamma <= gam[addr];
        beta  <= bet[addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] v;
        int           t0;
    } exp_t;
    exp_t sbq[$];

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    task automatic chk_vec(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
        int bad;
        bad = -1;
        checks++;
        for (int k = DIM - 1; k >= 0; k--)
            if (act[k*8 +: 8] !== req[k*8 +: 8]) bad = k;
        if (bad >= 0) begin
            fails++;
            $display("FAIL %s element %0d: got %0d, required %0d", nm, bad,
                     $signed(act[bad*8 +: 8]), $signed(req[bad*8 +: 8]));
        end
    endtask

    function automatic logic [W-1:0] mkvec(input logic [7:0] e, input logic [7:0] o);
        logic [W-1:0] v;
        for (int k = 0; k < DIM; k++) v[k*8 +: 8] = (k % 2 == 0) ? e : o;
        return v;
    endfunction

    task automatic set_rom(input logic [7:0] ge, input logic [7:0] go,
                           input logic [7:0] be, input logic [7:0] bo);
        for (int k = 0; k < DIM; k++) begin
            gam[k] = (k % 2 == 0) ? ge : go;
            bet[k] = (k % 2 == 0) ? be : bo;
        end
    endtask

    // monitor: every done pulse pops one expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sbq.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_done: got done at cycle %0d, required none", cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk_vec("out_vec", out_vec, e.v);
                chk("done_latency", cyc - e.t0, LAT);
            end
        end
    end

    task automatic start_op(input logic [W-1:0] v, input logic [W-1:0] expv);
        @(negedge clk);
        in_vec = v;
        start  = 1'b1;
        @(posedge clk);
        #1;
        sbq.push_back('{expv, cyc});
        start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk({nm, "_timeout"}, 1, 0);
    endtask

    logic [7:0] ev4;
    int busy_low;

    initial begin
`ifdef LAYERNORM_ROUND_EN
        ev4 = 8'd16;
`else
        ev4 = 8'd15;
`endif
        rst = 1'b1; start = 1'b0; in_vec = '0;
        set_rom(8'd64, 8'd64, 8'd0, 8'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out", int'(out_vec != '0), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_addr", int'(addr), 0);
        rst = 1'b0;

        // constant input: zero deviation, output equals beta
        set_rom(8'd64, 8'd64, 8'd3, 8'd3);
        start_op(mkvec(8'd5, 8'd5), mkvec(8'd3, 8'd3));
        wait_idle("t_const");
        chk("idle_addr", int'(addr), 0);

        // +8/-8: std 8, inv_std 8192
        set_rom(8'd64, 8'd64, 8'd0, 8'd0);
        start_op(mkvec(8'd8, 8'hF8), mkvec(8'd16, 8'hF0));
        wait_idle("t_pm8");

        // saturation at both ends
        set_rom(8'd127, 8'd127, 8'd120, 8'h88);
        start_op(mkvec(8'd8, 8'hF8), mkvec(8'd127, 8'h80));
        wait_idle("t_sat");

        // +3/-3: std 3, inv_std 21845, rounding-dependent even result
        set_rom(8'd64, 8'd64, 8'd0, 8'd0);
        start_op(mkvec(8'd3, 8'hFD), mkvec(ev4, 8'hF0));
        wait_idle("t_pm3");

        // start pulses and input churn while busy
        start_op(mkvec(8'd8, 8'hF8), mkvec(8'd16, 8'hF0));
        busy_low = 0;
        for (int i = 0; i < 380; i++) begin
            @(negedge clk);
            for (int j = 0; j < W / 32; j++) in_vec[j*32 +: 32] = $urandom();
            start = (i % 37 == 5);
            if (!busy) busy_low++;
        end
        start = 1'b0;
        chk("busy_held", busy_low, 0);
        for (int i = 0; i < 100 && !done; i++) @(negedge clk);
        chk("done_seen", int'(done), 1);
        // start raised during the done cycle must be ignored
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_in_done_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        chk("still_idle", int'(busy), 0);

        // reset in the middle of NORM abandons the operation
        start_op(mkvec(8'd8, 8'hF8), mkvec(8'd16, 8'hF0));
        repeat (300) @(posedge clk);
        @(negedge clk);
        sbq.delete();
        rst = 1'b1;
        #1;
        chk("midrst_out", int'(out_vec != '0), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_addr", int'(addr), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (450) @(negedge clk);
        chk("no_done_after_rst", int'(busy), 0);
        start_op(mkvec(8'd3, 8'hFD), mkvec(ev4, 8'hF0));
        wait_idle("t_after_rst");
        chk("queue_drained", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
